message_framer: RTL and testbench
=================================

MESSAGE_FRAMER -- requirements
Module: message_framer

Interface
REQ-001 Parameter DEPTH, default 8, is the message buffer depth in bytes; power of two, at least 4.
REQ-002 Parameter TERM, default 8'h00, is the message terminator byte.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream byte present.
REQ-006 in_byte  input  8  upstream ASCII byte.
REQ-007 in_ready  output  1  framer accepts in_byte this cycle.
REQ-008 key_load  input  1  load key_in into key register.
REQ-009 key_in  input  8  message private key.
REQ-010 out_valid  output  1  out_byte/out_key valid for the encrypter.
REQ-011 out_ready  input  1  downstream consumes this cycle.
REQ-012 out_byte  output  8  plaintext byte to the encrypter message input.
REQ-013 out_key  output  8  per-byte key to the encrypter key input.
REQ-014 out_last  output  1  current out_byte is the terminator.
REQ-015 msg_trunc  output  1  current message was truncated; meaningful only while out_last=1.

Function
REQ-016 FSM has three states: FILL, DRAIN, PAD.
REQ-017 An input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
REQ-018 in_ready=1 only in FILL; out_valid=1 only in DRAIN or PAD; in_ready and out_valid are never both 1.
REQ-019 In FILL, each input transfer writes in_byte to mem[wr_ptr] and increments wr_ptr and count.
REQ-020 FILL->DRAIN when the transferred byte equals TERM; the terminator is stored; msg_trunc is cleared.
REQ-021 FILL->DRAIN when a non-TERM byte makes count reach DEPTH-1; msg_trunc is set.
REQ-022 The first out_valid occurs the cycle after the FILL exit transfer (latency 1).
REQ-023 In DRAIN, out_byte=mem[rd_ptr]; each output transfer increments rd_ptr.
REQ-024 In DRAIN with msg_trunc=0, out_last=1 on the byte at rd_ptr==count-1; its transfer clears pointers and count and enters FILL.
REQ-025 In DRAIN with msg_trunc=1, out_last=0 throughout; the transfer at rd_ptr==count-1 enters PAD.
REQ-026 In PAD, out_byte=TERM and out_last=1; its transfer clears pointers, count and msg_trunc, and enters FILL.
REQ-027 out_key = key register rotated left by (byte index mod 8), where the byte index is rd_ptr in DRAIN and count in PAD.
REQ-028 key_load is honoured only in FILL with count==0; it is ignored at all other times.
REQ-029 If key_load and an input transfer occur in the same cycle, the new key applies to that message.
REQ-030 Outputs hold stable while out_valid=1 && out_ready=0.
REQ-031 A single TERM byte as the whole message produces one output: TERM, out_last=1, msg_trunc=0.
REQ-032 Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.

Reset
REQ-033 rst forces state FILL, wr_ptr, rd_ptr and count to 0, msg_trunc 0, and key register 8'h00.
REQ-034 During and after rst: in_ready=1 (the first cycle after rst deasserts), out_valid=0, out_last=0.
REQ-035 rst mid-message discards the partial message with no output; memory contents are not cleared.

Structure
REQ-036 Shared package encrypt_pkg holds DEPTH, TERM and the FSM state enum.
REQ-037 One sub-module, msg_fifo (storage plus pointers and count), is instantiated; FSM, key rotation and flags live in message_framer.

Verification
REQ-038 key 8'hA5; send "HI",00 (8'h48,8'h49,8'h00), out_ready=1 -> outputs 48/A5, 49/4B, 00/96; out_last on the third output only; msg_trunc=0.
REQ-039 Send 8'h41..8'h47 (7 bytes, DEPTH 8) -> in_ready drops after the 7th byte; outputs 41..47, then 00 with out_last=1 and msg_trunc=1; then FILL resumes.
REQ-040 Hold out_ready=0 for 5 cycles mid-DRAIN -> out_byte and out_key are unchanged; no byte is lost or duplicated.
REQ-041 Send a lone 8'h00 -> a single output 00 with out_last=1 and out_key equal to the loaded key.
REQ-042 Assert rst after 3 of 5 bytes -> no output; the next message "Z",00 is output correctly, with key reset to 00.
REQ-043 Pulse key_load with 8'h3C mid-fill -> ignored; out_key still derives from the prior key.

Source files
------------

// File: rtl/encrypt_pkg.sv
// Shared definitions for the message framer: default buffer depth, terminator
// byte, FSM state type and the key rotation helper.
package encrypt_pkg;

    localparam int         DEPTH = 8;
    localparam logic [7:0] TERM  = 8'h00;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        PAD   = 2'd2
    } state_t;

    function automatic logic [7:0] rotl8(input logic [7:0] k, input logic [2:0] n);
        logic [15:0] d;
        d = {k, k} << n;
        return d[15:8];
    endfunction

endpackage

// File: rtl/msg_fifo.sv
// Message byte storage with write/read pointers and a stored-byte count.
// The memory array is not reset; only the pointers and count are.
module msg_fifo #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic          clear,
    output logic [7:0]    rd_data,
    output logic [AW-1:0] rd_ptr,
    output logic [AW:0]   count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                count  <= count + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/message_framer.sv
// Collects a terminator-delimited message, then replays it byte by byte with a
// per-byte rotated key; truncated messages get an appended terminator.
module message_framer #(
    parameter int         DEPTH = encrypt_pkg::DEPTH,
    parameter logic [7:0] TERM  = encrypt_pkg::TERM
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    output logic       in_ready,
    input  logic       key_load,
    input  logic [7:0] key_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic [7:0] out_key,
    output logic       out_last,
    output logic       msg_trunc
);
    import encrypt_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    state_t        state, state_n;
    logic          trunc, trunc_n;
    logic [7:0]    key_reg;
    logic          wr_en, rd_en, clear;
    logic [7:0]    rd_data;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] byte_idx;
    logic          last_pos;

    msg_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (in_byte),
        .rd_en   (rd_en),
        .clear   (clear),
        .rd_data (rd_data),
        .rd_ptr  (rd_ptr),
        .count   (count)
    );

    assign last_pos = ({1'b0, rd_ptr} == count - CW'(1));

    always_comb begin
        state_n   = state;
        trunc_n   = trunc;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_byte  = rd_data;
        out_last  = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        clear     = 1'b0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (in_byte == TERM) begin
                        state_n = DRAIN;
                        trunc_n = 1'b0;
                    end else if (count == CW'(DEPTH - 2)) begin
                        state_n = DRAIN;
                        trunc_n = 1'b1;
                    end
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_last  = !trunc && last_pos;
                if (out_ready) begin
                    if (!last_pos) begin
                        rd_en = 1'b1;
                    end else if (trunc) begin
                        state_n = PAD;
                    end else begin
                        clear   = 1'b1;
                        state_n = FILL;
                    end
                end
            end
            PAD: begin
                out_valid = 1'b1;
                out_byte  = TERM;
                out_last  = 1'b1;
                if (out_ready) begin
                    clear   = 1'b1;
                    trunc_n = 1'b0;
                    state_n = FILL;
                end
            end
            default: state_n = FILL;
        endcase
        // Reset holds the upstream side open and the downstream side quiet.
        if (rst) begin
            in_ready  = 1'b1;
            out_valid = 1'b0;
            out_last  = 1'b0;
            wr_en     = 1'b0;
            rd_en     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FILL;
            trunc   <= 1'b0;
            key_reg <= 8'h00;
        end else begin
            state <= state_n;
            trunc <= trunc_n;
            if (key_load && state == FILL && count == '0) begin
                key_reg <= key_in;
            end
        end
    end

    assign byte_idx  = (state == PAD) ? count : {1'b0, rd_ptr};
    assign out_key   = rotl8(key_reg, 3'(byte_idx));
    assign msg_trunc = trunc;

endmodule

// File: tb/tb_message_framer.sv
// Self-checking bench for message_framer: directed vector tables, hand-written
// corner sequences and randomized messages checked against a message-level model.
module tb_message_framer;

    localparam int         DEPTH = 8;
    localparam logic [7:0] TERM  = 8'h00;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       in_ready;
    logic       key_load;
    logic [7:0] key_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic [7:0] out_key;
    logic       out_last;
    logic       msg_trunc;

    int vecs = 0;
    int miss = 0;
    logic [7:0] mkey;

    always #5 clk = ~clk;

    message_framer #(.DEPTH(DEPTH), .TERM(TERM)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_ready  (in_ready),
        .key_load  (key_load),
        .key_in    (key_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_key   (out_key),
        .out_last  (out_last),
        .msg_trunc (msg_trunc)
    );

    typedef struct {
        bit         send;
        logic [7:0] in_b;
        logic [7:0] e_b;
        logic [7:0] e_k;
        logic       e_l;
        logic       e_t;
    } vec_t;

    vec_t tbl [11];

    function automatic logic [7:0] mrot(input logic [7:0] k, input int s);
        logic [15:0] w;
        w = {8'h00, k};
        w = w << (s % 8);
        return w[7:0] | w[15:8];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input logic kl, input logic [7:0] kv);
        int t = 0;
        in_valid = 1'b1;
        in_byte  = b;
        key_load = kl;
        key_in   = kv;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        key_load = 1'b0;
    endtask

    task automatic load_key(input logic [7:0] k);
        key_load = 1'b1;
        key_in   = k;
        @(posedge clk);
        #1;
        key_load = 1'b0;
        mkey     = k;
    endtask

    task automatic recv(input int stall, output logic [7:0] b, output logic [7:0] k,
                        output logic l, output logic tr);
        int t = 0;
        out_ready = 1'b0;
        @(negedge clk);
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) chk("recv_timeout", 0, 1);
        b  = out_byte;
        k  = out_key;
        l  = out_last;
        tr = msg_trunc;
        repeat (stall) begin
            @(negedge clk);
            chk("stall_hold", {out_valid, out_byte, out_key, out_last}, {1'b1, b, k, l});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // Model: stored bytes replay with key rotated by index; a message without
    // a terminator gets one appended at index n, flagged truncated.
    task automatic expect_msg(input logic [7:0] q[$], input int stall_max, input int stall_at);
        logic [7:0] b, k;
        logic l, tr;
        int n;
        bit is_trunc;
        n = q.size();
        is_trunc = (q[n-1] != TERM);
        for (int i = 0; i < n; i++) begin
            int st;
            st = (i == stall_at) ? 5 : $urandom_range(0, stall_max);
            recv(st, b, k, l, tr);
            chk($sformatf("byte[%0d]", i), b, q[i]);
            chk($sformatf("key[%0d]", i), k, mrot(mkey, i));
            chk($sformatf("last[%0d]", i), l, (!is_trunc && i == n - 1));
            if (l) chk($sformatf("trunc[%0d]", i), tr, 0);
        end
        if (is_trunc) begin
            recv($urandom_range(0, stall_max), b, k, l, tr);
            chk("pad_byte", b, TERM);
            chk("pad_key", k, mrot(mkey, n));
            chk("pad_last", l, 1);
            chk("pad_trunc", tr, 1);
        end
        @(negedge clk);
        chk("refill_ready", {in_ready, out_valid}, 2'b10);
        @(posedge clk);
        #1;
    endtask

    task automatic run_msg(input logic [7:0] q[$], input int stall_max, input int stall_at,
                           input logic kl, input logic [7:0] kv);
        for (int i = 0; i < q.size(); i++) begin
            send_byte(q[i], (i == 0) ? kl : 1'b0, kv);
        end
        if (kl) mkey = kv;
        if (q[q.size()-1] != TERM) chk("trunc_ready_drop", in_ready, 0);
        expect_msg(q, stall_max, stall_at);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_outputs", {in_ready, out_valid, out_last}, 3'b100);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mkey = 8'h00;
        chk("post_rst_ready", {in_ready, out_valid, out_last}, 3'b100);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] b, k;
        logic l, tr;

        tbl[0]  = '{1, 8'h48, 8'h48, 8'hA5, 0, 0};
        tbl[1]  = '{1, 8'h49, 8'h49, 8'h4B, 0, 0};
        tbl[2]  = '{1, 8'h00, 8'h00, 8'h96, 1, 0};
        tbl[3]  = '{1, 8'h41, 8'h41, 8'hA5, 0, 0};
        tbl[4]  = '{1, 8'h42, 8'h42, 8'h4B, 0, 0};
        tbl[5]  = '{1, 8'h43, 8'h43, 8'h96, 0, 0};
        tbl[6]  = '{1, 8'h44, 8'h44, 8'h2D, 0, 0};
        tbl[7]  = '{1, 8'h45, 8'h45, 8'h5A, 0, 0};
        tbl[8]  = '{1, 8'h46, 8'h46, 8'hB4, 0, 0};
        tbl[9]  = '{1, 8'h47, 8'h47, 8'h69, 0, 0};
        tbl[10] = '{0, 8'h00, 8'h00, 8'hD2, 1, 1};

        rst = 1'b1; in_valid = 0; in_byte = 0; key_load = 0; key_in = 0; out_ready = 0;
        mkey = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // "HI",00 and a 7-byte truncated message, both with key A5
        load_key(8'hA5);
        for (int g = 0; g < 2; g++) begin
            int lo, hi;
            lo = (g == 0) ? 0 : 3;
            hi = (g == 0) ? 2 : 10;
            for (int i = lo; i <= hi; i++)
                if (tbl[i].send) send_byte(tbl[i].in_b, 1'b0, 8'h00);
            if (g == 1) chk("tbl_ready_drop", in_ready, 0);
            for (int i = lo; i <= hi; i++) begin
                recv(0, b, k, l, tr);
                chk($sformatf("tbl[%0d].byte", i), b, tbl[i].e_b);
                chk($sformatf("tbl[%0d].key", i), k, tbl[i].e_k);
                chk($sformatf("tbl[%0d].last", i), l, tbl[i].e_l);
                if (tbl[i].e_l) chk($sformatf("tbl[%0d].trunc", i), tr, tbl[i].e_t);
            end
            @(negedge clk);
            chk("tbl_refill", {in_ready, out_valid}, 2'b10);
            @(posedge clk);
            #1;
        end

        // 5-cycle stall on the second output
        q = '{8'h10, 8'h20, 8'h30, 8'h00};
        run_msg(q, 0, 1, 1'b0, 8'h00);

        // lone terminator, key loaded together with the byte
        q = '{8'h00};
        run_msg(q, 0, -1, 1'b1, 8'h77);

        // mid-fill key_load is ignored
        load_key(8'hC3);
        send_byte(8'h31, 1'b0, 8'h00);
        key_load = 1'b1; key_in = 8'h3C;
        @(posedge clk);
        #1;
        key_load = 1'b0;
        send_byte(8'h32, 1'b1, 8'h3C);
        send_byte(8'h00, 1'b0, 8'h00);
        q = '{8'h31, 8'h32, 8'h00};
        expect_msg(q, 1, -1);

        // reset mid-message discards it and clears the key
        load_key(8'h5E);
        send_byte(8'h61, 1'b0, 8'h00);
        send_byte(8'h62, 1'b0, 8'h00);
        send_byte(8'h63, 1'b0, 8'h00);
        do_reset();
        repeat (3) begin
            @(negedge clk);
            chk("no_output_after_rst", out_valid, 0);
        end
        @(posedge clk);
        #1;
        q = '{8'h5A, 8'h00};
        run_msg(q, 0, -1, 1'b0, 8'h00);

        // randomized messages
        for (int m = 0; m < 30; m++) begin
            logic kl;
            logic [7:0] kv;
            q.delete();
            kl = 1'($urandom_range(0, 1));
            kv = 8'($urandom_range(0, 255));
            forever begin
                logic [7:0] nb;
                nb = ($urandom_range(0, 4) == 0) ? TERM : 8'($urandom_range(1, 255));
                q.push_back(nb);
                if (nb == TERM || q.size() == DEPTH - 1) break;
            end
            run_msg(q, 3, -1, kl, kv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
